// File: rtl/oddr_tx_serializer.sv
// Purpose: serialize WIDTH-bit words into DDR bit pairs (D0 on SCLK high phase, D1 on low phase) for an output pad.
// Latency: word accepted at edge k shows pair 0 right after edge k; pair i follows edge k+i.
// Backpressure: DIN_READY is high only when idle or showing the last pair, so back-to-back words run with no gap.
//
// Ports:
//   SCLK       clock, all state on rising edge
//   RST        synchronous active-high reset
//   DIN        parallel word, sampled only on accept
//   DIN_VALID  DIN holds a word
//   DIN_READY  block takes DIN at the next rising edge when DIN_VALID=1
//   D0_OUT     registered high-phase bit of the current pair
//   D1_OUT     registered low-phase bit of the current pair
//   FRAME      current pair is pair 0 of a word
//   BUSY       a word is being shifted out
//   Q          behavioural DDR mux of D0_OUT/D1_OUT selected by SCLK level
module oddr_tx_serializer #(
    parameter int   WIDTH     = 8,
    parameter logic IDLE_VAL  = 1'b0,
    parameter bit   MSB_FIRST = 1'b0
) (
    input  logic             SCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             D0_OUT,
    output logic             D1_OUT,
    output logic             FRAME,
    output logic             BUSY,
    output logic             Q
);

    localparam int NPAIRS = WIDTH / 2;
    localparam int CW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NPAIRS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;      // pairs still to emit after the current one
    logic [WIDTH-1:0] r_sr;       // remaining pairs, next pair in bits [1:0]
    logic             r_d0;
    logic             r_d1;
    logic             r_frame;

    logic [WIDTH-1:0] w_word;     // DIN reordered so pair 0 always sits in bits [1:0]
    logic             w_last;
    logic             w_ready;
    logic             w_accept;

    // Mirroring the word lets one LSB-first shift path serve both orders:
    // with MSB_FIRST, DIN[W-1] lands in bit 0 and becomes D0 of pair 0.
    always_comb begin
        w_word = DIN;
        if (MSB_FIRST) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_word[j] = DIN[WIDTH-1-j];
            end
        end
    end

    assign w_last   = (r_cnt == '0);
    assign w_ready  = !RST && ((r_state == ST_IDLE) || w_last);
    assign w_accept = DIN_VALID && w_ready;

    always_ff @(posedge SCLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_d0    <= IDLE_VAL;
            r_d1    <= IDLE_VAL;
            r_frame <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_d0    <= w_word[0];
                        r_d1    <= w_word[1];
                        r_sr    <= w_word >> 2;
                        r_cnt   <= CNT_LAST;
                        r_frame <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_d0    <= IDLE_VAL;
                        r_d1    <= IDLE_VAL;
                        r_frame <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_d0    <= r_sr[0];
                        r_d1    <= r_sr[1];
                        r_sr    <= r_sr >> 2;
                        r_cnt   <= r_cnt - 1'b1;
                        r_frame <= 1'b0;
                    end else if (w_accept) begin
                        // Back-to-back word: pair 0 follows the last pair directly.
                        r_d0    <= w_word[0];
                        r_d1    <= w_word[1];
                        r_sr    <= w_word >> 2;
                        r_cnt   <= CNT_LAST;
                        r_frame <= 1'b1;
                    end else begin
                        // Underrun: drop to the idle level until the next word.
                        r_d0    <= IDLE_VAL;
                        r_d1    <= IDLE_VAL;
                        r_frame <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_d0    <= IDLE_VAL;
                    r_d1    <= IDLE_VAL;
                    r_frame <= 1'b0;
                end
            endcase
        end
    end

    assign DIN_READY = w_ready;
    assign D0_OUT    = r_d0;
    assign D1_OUT    = r_d1;
    assign FRAME     = r_frame;
    assign BUSY      = (r_state == ST_SHIFT);

    // Simulation model of the pad DDR mux; X when the clock level is unknown.
    assign Q = (SCLK === 1'b1) ? r_d0 : ((SCLK === 1'b0) ? r_d1 : 1'bx);

endmodule

// File: tb/tb_oddr_tx_serializer.sv
module tb_oddr_tx_serializer;

    logic       SCLK;
    logic       RST;
    logic [7:0] DIN;
    logic       DIN_VALID;

    logic [2:0] rdy, d0, d1, fr, bz, q;

    // dut 0: WIDTH=8 LSB-first, dut 1: WIDTH=8 MSB-first, dut 2: WIDTH=2
    oddr_tx_serializer #(.WIDTH(8), .IDLE_VAL(1'b0), .MSB_FIRST(1'b0)) u_lsb (
        .SCLK(SCLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy[0]), .D0_OUT(d0[0]), .D1_OUT(d1[0]), .FRAME(fr[0]),
        .BUSY(bz[0]), .Q(q[0]));

    oddr_tx_serializer #(.WIDTH(8), .IDLE_VAL(1'b0), .MSB_FIRST(1'b1)) u_msb (
        .SCLK(SCLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy[1]), .D0_OUT(d0[1]), .D1_OUT(d1[1]), .FRAME(fr[1]),
        .BUSY(bz[1]), .Q(q[1]));

    oddr_tx_serializer #(.WIDTH(2), .IDLE_VAL(1'b0), .MSB_FIRST(1'b0)) u_w2 (
        .SCLK(SCLK), .RST(RST), .DIN(DIN[1:0]), .DIN_VALID(DIN_VALID),
        .DIN_READY(rdy[2]), .D0_OUT(d0[2]), .D1_OUT(d1[2]), .FRAME(fr[2]),
        .BUSY(bz[2]), .Q(q[2]));

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int total = 0;
    int bad   = 0;

    // Reference model: each dut has a word and the index of the next pair to show.
    int         npv[3]  = '{4, 4, 1};
    int         wv[3]   = '{8, 8, 2};
    bit         msbv[3] = '{1'b0, 1'b1, 1'b0};
    int         nxt[3];
    logic [7:0] mword[3];
    logic [1:0] lb_q[$];     // loopback scoreboard for dut 0, {D1,D0} per pair

    // Values captured by the last cycle() call.
    logic cap_rdy[3], cap_qh[3], cap_ql[3], cap_fr[3], cap_bz[3];
    logic acc_last[3];

    function automatic logic [1:0] pair_of(input logic [7:0] w, input int width,
                                           input bit msb, input int i);
        if (!msb) return {w[2*i+1], w[2*i]};
        return {w[width-2-2*i], w[width-1-2*i]};
    endfunction

    task automatic chk(input string nm, input int d, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%b want=%b t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs in the low phase, check ready, then check
    // the pair shown in the following high and low phases.
    task automatic cycle(input logic rst, input logic vld, input logic [7:0] din);
        logic       show[3];
        logic [1:0] ep[3];
        int         idx;
        RST = rst; DIN_VALID = vld; DIN = din;
        #1;
        for (int d = 0; d < 3; d++) begin
            logic er;
            er = !rst && (nxt[d] >= npv[d]);
            cap_rdy[d] = rdy[d];
            chk("ready", d, {1'b0, rdy[d]}, {1'b0, er});
            acc_last[d] = vld && er;
        end
        @(posedge SCLK);
        for (int d = 0; d < 3; d++) begin
            idx = 0;
            if (rst) begin
                nxt[d] = npv[d]; show[d] = 1'b0;
                if (d == 0) lb_q.delete();
            end else if (acc_last[d]) begin
                mword[d] = din; show[d] = 1'b1; idx = 0; nxt[d] = 1;
                if (d == 0)
                    for (int i = 0; i < npv[0]; i++) lb_q.push_back(pair_of(din, 8, 1'b0, i));
            end else if (nxt[d] < npv[d]) begin
                show[d] = 1'b1; idx = nxt[d]; nxt[d]++;
            end else begin
                show[d] = 1'b0;
            end
            ep[d] = show[d] ? pair_of(mword[d], wv[d], msbv[d], idx) : 2'b00;
            if (show[d] && idx == 0) cap_fr[d] = 1'b1; else cap_fr[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("d0_out", d, {1'b0, d0[d]}, {1'b0, ep[d][0]});
            chk("d1_out", d, {1'b0, d1[d]}, {1'b0, ep[d][1]});
            chk("frame",  d, {1'b0, fr[d]}, {1'b0, cap_fr[d]});
            chk("busy",   d, {1'b0, bz[d]}, {1'b0, show[d]});
            chk("q_high", d, {1'b0, q[d]},  {1'b0, ep[d][0]});
            cap_qh[d] = q[d]; cap_fr[d] = fr[d]; cap_bz[d] = bz[d];
        end
        @(negedge SCLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("q_low", d, {1'b0, q[d]}, {1'b0, ep[d][1]});
            cap_ql[d] = q[d];
        end
        // Receiver view of dut 0: {Q1,Q0} = {low-phase, high-phase} sample.
        if (show[0]) begin
            if (lb_q.size() == 0) chk("loopback_underflow", 0, 2'b01, 2'b00);
            else chk("loopback", 0, {cap_ql[0], cap_qh[0]}, lb_q.pop_front());
        end
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic       qh;
        logic       ql;
        logic       fr;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic vld, input logic [7:0] din, input logic rdy_e,
                       input logic qh, input logic ql, input logic f, input logic b);
        vec_t v;
        v.rst = rst; v.vld = vld; v.din = din; v.rdy = rdy_e;
        v.qh = qh; v.ql = ql; v.fr = f; v.bz = b;
        tbl.push_back(v);
    endtask

    initial begin
        int n_words;
        int cyc;
        for (int d = 0; d < 3; d++) begin nxt[d] = npv[d]; mword[d] = '0; end
        RST = 1'b1; DIN_VALID = 1'b0; DIN = '0;

        // Expected values for dut 0 (WIDTH=8, LSB first).
        // reset held 3 edges with DIN_VALID=1
        add(1,1,8'hAA, 0, 0,0,0,0); add(1,1,8'hAA, 0, 0,0,0,0); add(1,1,8'hAA, 0, 0,0,0,0);
        // 8'hB4 single word: 0,0 | 1,0 | 1,1 | 0,1 then idle
        add(0,1,8'hB4, 1, 0,0,1,1); add(0,0,8'h00, 0, 1,0,0,1);
        add(0,0,8'h00, 0, 1,1,0,1); add(0,0,8'h00, 0, 0,1,0,1);
        add(0,0,8'h00, 1, 0,0,0,0); add(0,0,8'h00, 1, 0,0,0,0);
        // back-to-back 8'hFF then 8'h00, DIN_VALID held
        add(0,1,8'hFF, 1, 1,1,1,1); add(0,1,8'h00, 0, 1,1,0,1);
        add(0,1,8'h00, 0, 1,1,0,1); add(0,1,8'h00, 0, 1,1,0,1);
        add(0,1,8'h00, 1, 0,0,1,1); add(0,0,8'h00, 0, 0,0,0,1);
        add(0,0,8'h00, 0, 0,0,0,1); add(0,0,8'h00, 0, 0,0,0,1);
        add(0,0,8'h00, 1, 0,0,0,0);
        // reset during pair 1 of 8'hAA, then a clean 8'h0F
        add(0,1,8'hAA, 1, 0,1,1,1); add(0,0,8'h00, 0, 0,1,0,1);
        add(1,0,8'h00, 0, 0,0,0,0); add(0,1,8'h0F, 1, 1,1,1,1);
        add(0,0,8'h00, 0, 1,1,0,1); add(0,0,8'h00, 0, 0,0,0,1);
        add(0,0,8'h00, 0, 0,0,0,1); add(0,0,8'h00, 1, 0,0,0,0);

        @(negedge SCLK); #1;
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].din);
            chk("tbl_ready", i, {1'b0, cap_rdy[0]}, {1'b0, tbl[i].rdy});
            chk("tbl_q_hi",  i, {1'b0, cap_qh[0]},  {1'b0, tbl[i].qh});
            chk("tbl_q_lo",  i, {1'b0, cap_ql[0]},  {1'b0, tbl[i].ql});
            chk("tbl_frame", i, {1'b0, cap_fr[0]},  {1'b0, tbl[i].fr});
            chk("tbl_busy",  i, {1'b0, cap_bz[0]},  {1'b0, tbl[i].bz});
        end

        // MSB_FIRST with 8'h80: only the first high phase is 1.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h80);
        chk("msb_first_hi", 1, {1'b0, cap_qh[1]}, 2'b01);
        chk("msb_first_lo", 1, {1'b0, cap_ql[1]}, 2'b00);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 8'hFF);
            chk("msb_later_hi", 1, {1'b0, cap_qh[1]}, 2'b00);
            chk("msb_later_lo", 1, {1'b0, cap_ql[1]}, 2'b00);
        end

        // WIDTH=2: ready every cycle, every pair is a new frame.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 8'($urandom));
            chk("w2_ready", 2, {1'b0, cap_rdy[2]}, 2'b01);
            chk("w2_frame", 2, {1'b0, cap_fr[2]},  2'b01);
        end
        cycle(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 8'h00);

        // Random stream with gaps: 500 words into dut 0 through the loopback scoreboard.
        n_words = 0;
        cyc = 0;
        while (n_words < 500 && cyc < 20000) begin
            cycle(1'b0, ($urandom_range(0, 9) < 7), 8'($urandom));
            if (acc_last[0]) n_words++;
            cyc++;
        end
        if (n_words < 500) chk("stream_budget", 0, 2'b00, 2'b01);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 8'h00);
        chk("loopback_drained", 0, (lb_q.size() == 0) ? 2'b00 : 2'b01, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
